// File: rtl/exc_pkg.sv
// Shared constants and types for the exception/return sequencer:
// CP0 addresses, ExcCode values, FSM states and CP0 word packing helpers.
package exc_pkg;

  localparam logic [7:0] CP0_STATUS = {5'd12, 3'd0};
  localparam logic [7:0] CP0_CAUSE  = {5'd13, 3'd0};
  localparam logic [7:0] CP0_EPC    = {5'd14, 3'd0};

  localparam logic [4:0] EXC_INT = 5'd0;
  localparam logic [4:0] EXC_SYS = 5'd8;
  localparam logic [4:0] EXC_BP  = 5'd9;
  localparam logic [4:0] EXC_OV  = 5'd12;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FLUSH    = 2'd1,
    REDIRECT = 2'd2
  } exc_state_e;

  typedef struct packed {
    logic ov;
    logic sys;
    logic brk;
    logic eret;
  } exc_evt_t;

  function automatic logic [31:0] status_word(input logic [5:0] im,
                                               input logic       exl,
                                               input logic       ie);
    return {16'h0000, im, 8'h00, exl, ie};
  endfunction

  function automatic logic [31:0] cause_word(input logic [5:0] ip,
                                              input logic [4:0] code);
    return {16'h0000, ip, 3'b000, code, 2'b00};
  endfunction

endpackage

// File: rtl/exc_ctrl_if.sv
// Writeback-side bundle of the exception sequencer: event inputs, CP0 access
// and the cancel/redirect handshake back to the pipeline.
interface exc_ctrl_if;
  logic        wb_valid;
  logic [31:0] wb_pc;
  logic        wb_syscall;
  logic        wb_break;
  logic        wb_ov;
  logic        wb_eret;
  logic        wb_mtc0;
  logic [7:0]  wb_cp0_addr;
  logic [31:0] wb_cp0_wdata;
  logic [5:0]  hw_int;
  logic [31:0] cp0_rdata;
  logic        cancel;
  logic        busy;
  logic        exc_valid;
  logic [31:0] exc_pc;

  modport master (
    output wb_valid, wb_pc, wb_syscall, wb_break, wb_ov, wb_eret,
           wb_mtc0, wb_cp0_addr, wb_cp0_wdata, hw_int,
    input  cp0_rdata, cancel, busy, exc_valid, exc_pc
  );

  modport slave (
    input  wb_valid, wb_pc, wb_syscall, wb_break, wb_ov, wb_eret,
           wb_mtc0, wb_cp0_addr, wb_cp0_wdata, hw_int,
    output cp0_rdata, cancel, busy, exc_valid, exc_pc
  );
endinterface

// File: rtl/exc_prio_enc.sv
// Combinational priority encoder for writeback exception events:
// interrupt > overflow > syscall > break > eret.
module exc_prio_enc
  import exc_pkg::*;
(
  input  exc_evt_t   evt,
  input  logic       ie,
  input  logic       exl,
  input  logic [5:0] im,
  input  logic [5:0] hw_int,
  output logic       taken,
  output logic       is_eret,
  output logic [4:0] code
);

  logic int_req;

  // Interrupts are masked while already inside a handler (EXL set)
  assign int_req = ie && !exl && (|(im & hw_int));

  always_comb begin
    taken   = 1'b1;
    is_eret = 1'b0;
    code    = EXC_INT;
    if (int_req) begin
      code = EXC_INT;
    end else if (evt.ov) begin
      code = EXC_OV;
    end else if (evt.sys) begin
      code = EXC_SYS;
    end else if (evt.brk) begin
      code = EXC_BP;
    end else if (evt.eret) begin
      is_eret = 1'b1;
    end else begin
      taken = 1'b0;
    end
  end

endmodule

// File: rtl/exc_ctrl.sv
// Exception/return sequencer beside writeback: owns CP0 STATUS/CAUSE/EPC and
// runs IDLE -> FLUSH -> REDIRECT. Interrupt support is built when EXC_INT_EN is defined.
module exc_ctrl
  import exc_pkg::*;
#(
  parameter logic [31:0] EXC_ENTER_ADDR = 32'h0000_0000,
  parameter int unsigned FLUSH_CYCLES   = 2
) (
  input logic       clk,
  input logic       resetn,
  exc_ctrl_if.slave bus
);

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

  exc_state_e  state;
  logic [2:0]  flush_cnt;
  logic [31:0] target;
  logic        cancel_q;
  logic        busy_q;
  logic        exc_valid_q;
  logic [31:0] exc_pc_q;

  logic [31:0] epc;
  logic        status_exl;
  logic [4:0]  cause_exc;
  logic [5:0]  status_im;
  logic        status_ie;
  logic [5:0]  cause_ip;

  exc_evt_t    evt;
  logic        enc_taken;
  logic        enc_eret;
  logic [4:0]  enc_code;
  logic        sample;
  logic        take;
  logic        do_mtc0;

  assign evt = '{ov: bus.wb_ov, sys: bus.wb_syscall, brk: bus.wb_break, eret: bus.wb_eret};

  exc_prio_enc u_prio (
    .evt     (evt),
    .ie      (status_ie),
    .exl     (status_exl),
    .im      (status_im),
    .hw_int  (bus.hw_int),
    .taken   (enc_taken),
    .is_eret (enc_eret),
    .code    (enc_code)
  );

  // Anything arriving outside IDLE belongs to an already-cancelled instruction
  assign sample  = (state == IDLE) && bus.wb_valid;
  assign take    = sample && enc_taken;
  assign do_mtc0 = sample && bus.wb_mtc0 && !enc_taken;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      flush_cnt   <= '0;
      target      <= '0;
      cancel_q    <= 1'b0;
      busy_q      <= 1'b0;
      exc_valid_q <= 1'b0;
      exc_pc_q    <= '0;
    end else begin
      exc_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (take) begin
            state     <= FLUSH;
            flush_cnt <= FLUSH_LOAD;
            cancel_q  <= 1'b1;
            busy_q    <= 1'b1;
            target    <= enc_eret ? epc : EXC_ENTER_ADDR;
          end
        end
        FLUSH: begin
          if (flush_cnt == 3'd0) begin
            state       <= REDIRECT;
            cancel_q    <= 1'b0;
            exc_valid_q <= 1'b1;
            exc_pc_q    <= target;
          end else begin
            flush_cnt <= flush_cnt - 3'd1;
          end
        end
        REDIRECT: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          cancel_q <= 1'b0;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

  // EPC/EXL/ExcCode: a taken event wins over a same-cycle mtc0
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      epc        <= '0;
      status_exl <= 1'b0;
      cause_exc  <= '0;
    end else if (take) begin
      if (enc_eret) begin
        status_exl <= 1'b0;
      end else begin
        epc        <= bus.wb_pc;
        cause_exc  <= enc_code;
        status_exl <= 1'b1;
      end
    end else if (do_mtc0) begin
      if (bus.wb_cp0_addr == CP0_EPC)    epc        <= bus.wb_cp0_wdata;
      if (bus.wb_cp0_addr == CP0_STATUS) status_exl <= bus.wb_cp0_wdata[1];
    end
  end

`ifdef EXC_INT_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      status_im <= '0;
      status_ie <= 1'b0;
      cause_ip  <= '0;
    end else begin
      cause_ip <= bus.hw_int;
      if (do_mtc0 && (bus.wb_cp0_addr == CP0_STATUS)) begin
        status_im <= bus.wb_cp0_wdata[15:10];
        status_ie <= bus.wb_cp0_wdata[0];
      end
    end
  end
`else
  // Without interrupt support IM/IE/IP are hard zero, which also disables priority 1
  assign status_im = '0;
  assign status_ie = 1'b0;
  assign cause_ip  = '0;
`endif

  always_comb begin
    bus.cp0_rdata = '0;
    case (bus.wb_cp0_addr)
      CP0_STATUS: bus.cp0_rdata = status_word(status_im, status_exl, status_ie);
      CP0_CAUSE:  bus.cp0_rdata = cause_word(cause_ip, cause_exc);
      CP0_EPC:    bus.cp0_rdata = epc;
      default:    bus.cp0_rdata = '0;
    endcase
  end

  assign bus.cancel    = cancel_q;
  assign bus.busy      = busy_q;
  assign bus.exc_valid = exc_valid_q;
  assign bus.exc_pc    = exc_pc_q;

endmodule

// File: doc/exc_ctrl.md
Name: exc_ctrl

Overview:
- Exception/return sequencer for the MIPS pipeline, located beside the writeback stage.
- Owns CP0 STATUS, CAUSE and EPC. Prioritises simultaneous exception events from the writeback instruction.
- Runs a flush → redirect sequence: holds the pipeline cancelled for a fixed number of cycles, then issues a single redirect pulse to instruction fetch (IF).
- Replaces ad-hoc same-cycle cancel and redirect logic with a deterministic multi-cycle handshake.

Parameters:
- EXC_ENTER_ADDR, 32'h0000_0000: exception entry vector.
- FLUSH_CYCLES, 2: number of cycles cancel is held. Legal range 1..7.

Ports:
- clk  in  1  clock.
- resetn  in  1  asynchronous active-low reset.
- wb_valid  in  1  writeback instruction is valid this cycle.
- wb_pc  in  32  PC of the writeback instruction.
- wb_syscall  in  1  syscall event.
- wb_break  in  1  break event.
- wb_ov  in  1  arithmetic overflow event.
- wb_eret  in  1  eret event.
- wb_mtc0  in  1  CP0 write request.
- wb_cp0_addr  in  8  CP0 address, encoded {reg[4:0], sel[2:0]}.
- wb_cp0_wdata  in  32  CP0 write data.
- hw_int  in  6  hardware interrupt lines, level-sensitive.
- cp0_rdata  out  32  combinational read of the register at wb_cp0_addr.
- cancel  out  1  flush all pipeline stages.
- busy  out  1  IF stall; high whenever state ≠ IDLE.
- exc_valid  out  1  one-cycle redirect strobe.
- exc_pc  out  32  redirect target; meaningful only while exc_valid = 1.

Behaviour:
- Reset (asynchronous): state = IDLE; cancel, busy, exc_valid = 0; exc_pc = 0; EPC = 0; STATUS = 0; CAUSE = 0.
- STATUS (12,0) layout: [15:10] IM, [1] EXL, [0] IE. All other bits read 0.
- CAUSE (13,0) layout: [15:10] IP, [6:2] ExcCode. All other bits read 0.
  - IP is a registered copy of hw_int, updated every cycle including when not IDLE.
  - CAUSE is not software-writable.
- EPC (14,0): full 32 bits, software-writable.
- Any other CP0 address reads 0; writes to it are ignored.
- Events are sampled only when state = IDLE and wb_valid = 1.
- Event priority, highest first:
  1. Interrupt: (hw_int & IM) ≠ 0, IE = 1, EXL = 0. Code 0.
  2. Overflow. Code 12.
  3. Syscall. Code 8.
  4. Break. Code 9.
  5. Eret.
- Exception taken (priorities 1–4):
  - EPC ← wb_pc; ExcCode ← code; EXL ← 1.
  - Latched target = EXC_ENTER_ADDR.
- Eret taken:
  - EXL ← 0.
  - Latched target = EPC value before the cycle's update. A same-cycle mtc0 to EPC is ignored.
- mtc0:
  - Applied only in IDLE with no exception or eret taken that cycle; otherwise the write is dropped.
  - STATUS write updates IM, EXL and IE only.
- FSM:
  - IDLE → FLUSH when any event is taken. Counter loaded with FLUSH_CYCLES-1.
  - FLUSH: cancel = 1, busy = 1. Counter decrements each cycle; at 0 → REDIRECT.
  - REDIRECT: exc_valid = 1, exc_pc = latched target, cancel = 0, busy = 1. Next state IDLE.
- Timing: event sampled at edge N → cancel high for cycles N+1 .. N+FLUSH_CYCLES → exc_valid high at cycle N+FLUSH_CYCLES+1 → IDLE from N+FLUSH_CYCLES+2.
- Events, wb_valid and mtc0 arriving while not IDLE are ignored. These instructions are already cancelled.
- A nested exception is impossible while EXL = 1 for interrupts only. Synchronous exceptions are still taken and overwrite EPC.
- resetn asserted mid-sequence: immediate return to IDLE; no redirect is issued.
- wb_valid = 0 masks every event, including interrupts.

Optional Feature:
- Macro: EXC_INT_EN.
- Defined: interrupt path, IM, IE and IP are implemented as described above.
- Undefined:
  - hw_int is ignored.
  - IM, IE and IP read 0; STATUS writes update EXL only.
  - Priority 1 does not exist.

Decomposition:
- Shared package exc_pkg holds:
  - CP0 address constants: CP0_STATUS = {5'd12,3'd0}, CP0_CAUSE, CP0_EPC.
  - ExcCode constants: EXC_INT = 0, EXC_SYS = 8, EXC_BP = 9, EXC_OV = 12.
  - FSM state encoding: IDLE, FLUSH, REDIRECT.
- One sub-module: exc_prio_enc. Combinational priority encoder, inputs = event vector plus IE/EXL/IM/hw_int, outputs = taken / is_eret / code.
- CP0 registers and FSM stay in exc_ctrl.

Test Plan:
- Basic syscall: FLUSH_CYCLES = 2, syscall at wb_pc = 32'h0000_0040 → cancel high 2 cycles; then exc_valid = 1, exc_pc = 0. EPC = 0x40, CAUSE = 0x20, STATUS.EXL = 1.
- Eret return: eret after the syscall above → EXL = 0; exc_valid with exc_pc = 0x40 three cycles after sampling.
- Same-cycle priority: wb_ov and wb_syscall together at pc 0x80 → ExcCode = 12, EPC = 0x80. Exactly one redirect pulse.
- Mid-sequence mtc0 and reset: mtc0 EPC = 0x1234 issued during FLUSH → EPC unchanged. resetn pulsed during FLUSH → all outputs 0; no exc_valid afterwards.
- Interrupt (EXC_INT_EN defined): IM = 6'b000001, IE = 1, hw_int[0] = 1, wb_pc = 0x100 → ExcCode = 0, EPC = 0x100. A second interrupt is ignored while EXL = 1.
- Interrupt disabled (EXC_INT_EN undefined): hw_int = 6'h3F with IE written 1 → no sequence started; STATUS reads 0 except EXL.
